// File: rtl/cr16_alu_ctrl_if.sv
// Instruction handshake, register-file and ALU bus between the CR16 sequencer and its datapath.
// The slave modport is the controller; the master modport is the instruction source plus datapath.
interface cr16_alu_ctrl_if #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned FLAG_WIDTH     = 5
);
    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned OPC_WIDTH   = 4;

    logic                      I_instr_valid;
    logic                      O_instr_ready;
    logic [INSTR_WIDTH-1:0]    I_instr;
    logic [REG_ADDR_WIDTH-1:0] O_rf_raddr_a;
    logic [REG_ADDR_WIDTH-1:0] O_rf_raddr_b;
    logic [DATA_WIDTH-1:0]     I_rf_rdata_a;
    logic [DATA_WIDTH-1:0]     I_rf_rdata_b;
    logic                      O_rf_we;
    logic [REG_ADDR_WIDTH-1:0] O_rf_waddr;
    logic [DATA_WIDTH-1:0]     O_rf_wdata;
    logic [DATA_WIDTH-1:0]     O_alu_op1;
    logic [DATA_WIDTH-1:0]     O_alu_op2;
    logic [OPC_WIDTH-1:0]      O_alu_opcode;
    logic [DATA_WIDTH-1:0]     I_alu_dest;
    logic [FLAG_WIDTH-1:0]     I_alu_flags;

    modport slave (
        input  I_instr_valid, I_instr, I_rf_rdata_a, I_rf_rdata_b, I_alu_dest, I_alu_flags,
        output O_instr_ready, O_rf_raddr_a, O_rf_raddr_b, O_rf_we, O_rf_waddr, O_rf_wdata,
               O_alu_op1, O_alu_op2, O_alu_opcode
    );

    modport master (
        output I_instr_valid, I_instr, I_rf_rdata_a, I_rf_rdata_b, I_alu_dest, I_alu_flags,
        input  O_instr_ready, O_rf_raddr_a, O_rf_raddr_b, O_rf_we, O_rf_waddr, O_rf_wdata,
               O_alu_op1, O_alu_op2, O_alu_opcode
    );
endinterface

// File: rtl/cr16_alu_ctrl.sv
// CR16 ALU sequencer: IDLE -> READ -> EXEC -> WB, one instruction in flight at a time.
// Optional retired-instruction counter enabled by defining CR16_ALU_CTRL_STATS_EN.
module cr16_alu_ctrl #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned FLAG_WIDTH     = 5,
    parameter logic [3:0]  CMP_OPEXT      = 4'b1011
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET,
    cr16_alu_ctrl_if.slave        bus,
    output logic [FLAG_WIDTH-1:0] O_psr_flags,
    output logic                  O_busy
`ifdef CR16_ALU_CTRL_STATS_EN
    ,
    output logic [15:0]           O_retired_count
`endif
);
    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned OPC_WIDTH   = 4;
    localparam int unsigned IMM_WIDTH   = 8;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [INSTR_WIDTH-1:0]    r_instr;
    logic [REG_ADDR_WIDTH-1:0] r_raddr_a;
    logic [REG_ADDR_WIDTH-1:0] r_raddr_b;
    logic [OPC_WIDTH-1:0]      r_opcode;
    logic [DATA_WIDTH-1:0]     r_op1;
    logic [DATA_WIDTH-1:0]     r_op2;
    logic [DATA_WIDTH-1:0]     r_result;
    logic [FLAG_WIDTH-1:0]     r_flags;
    logic [REG_ADDR_WIDTH-1:0] r_waddr;
    logic [FLAG_WIDTH-1:0]     r_psr;

    logic                      w_handshake;
    logic                      w_in_reg_form;
    logic [OPC_WIDTH-1:0]      w_in_opcode;
    logic                      w_reg_form;
    logic                      w_is_cmp;
    logic [DATA_WIDTH-1:0]     w_imm;
    logic [DATA_WIDTH-1:0]     w_op2;

    // Decode of the incoming word (for handshake-time loads) and of the latched word
    assign w_handshake   = bus.I_instr_valid && (r_state == S_IDLE);
    assign w_in_reg_form = (bus.I_instr[15:12] == 4'b0000);
    assign w_in_opcode   = w_in_reg_form ? bus.I_instr[7:4] : bus.I_instr[15:12];
    assign w_reg_form    = (r_instr[15:12] == 4'b0000);
    assign w_is_cmp      = w_reg_form && (r_instr[7:4] == CMP_OPEXT);
    assign w_imm         = {{(DATA_WIDTH-IMM_WIDTH){r_instr[IMM_WIDTH-1]}}, r_instr[IMM_WIDTH-1:0]};
    assign w_op2         = w_reg_form ? bus.I_rf_rdata_b : w_imm;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_handshake) w_state_next = S_READ;
            S_READ:  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ALU operands pass the read data through during EXEC and hold it afterwards
    always_comb begin
        bus.O_instr_ready = (r_state == S_IDLE);
        O_busy            = (r_state != S_IDLE);
        bus.O_rf_we       = (r_state == S_WB) && !w_is_cmp && !I_RESET;
        bus.O_alu_op1     = r_op1;
        bus.O_alu_op2     = r_op2;
        if (r_state == S_EXEC) begin
            bus.O_alu_op1 = bus.I_rf_rdata_a;
            bus.O_alu_op2 = w_op2;
        end
    end

    assign bus.O_rf_raddr_a = r_raddr_a;
    assign bus.O_rf_raddr_b = r_raddr_b;
    assign bus.O_alu_opcode = r_opcode;
    assign bus.O_rf_waddr   = r_waddr;
    assign bus.O_rf_wdata   = r_result;
    assign O_psr_flags      = r_psr;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_instr   <= '0;
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_opcode  <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_waddr   <= '0;
            r_psr     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_instr   <= bus.I_instr;
                        r_raddr_a <= bus.I_instr[11:8];
                        r_raddr_b <= bus.I_instr[3:0];
                        r_opcode  <= w_in_opcode;
                    end
                end
                S_EXEC: begin
                    r_op1    <= bus.I_rf_rdata_a;
                    r_op2    <= w_op2;
                    r_result <= bus.I_alu_dest;
                    r_flags  <= bus.I_alu_flags;
                    r_waddr  <= r_instr[11:8];
                end
                S_WB:    r_psr <= r_flags;
                default: ;
            endcase
        end
    end

`ifdef CR16_ALU_CTRL_STATS_EN
    logic [15:0] r_retired;

    // Counts every completed WB, compares included; wraps naturally
    always_ff @(posedge I_CLK) begin
        if (I_RESET)               r_retired <= '0;
        else if (r_state == S_WB)  r_retired <= r_retired + 16'd1;
    end

    assign O_retired_count = r_retired;
`endif
endmodule

// File: tb/tb_cr16_alu_ctrl.sv
// Directed bench for cr16_alu_ctrl with a register-file model and a simple ALU model.
module tb_cr16_alu_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned FW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rf_clear;
    logic [FW-1:0] psr;
    logic          busy;
`ifdef CR16_ALU_CTRL_STATS_EN
    logic [15:0]   retired;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cr16_alu_ctrl_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FLAG_WIDTH(FW)) bus ();

    cr16_alu_ctrl dut (
        .I_CLK       (clk),
        .I_RESET     (rst),
        .bus         (bus),
        .O_psr_flags (psr),
        .O_busy      (busy)
`ifdef CR16_ALU_CTRL_STATS_EN
        ,
        .O_retired_count (retired)
`endif
    );

    // Register file: synchronous read, write on O_rf_we
    logic [DW-1:0] regs [16];
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            regs[1] <= 16'd3;
            regs[2] <= 16'd4;
            regs[3] <= 16'h0010;
        end else if (bus.O_rf_we) begin
            regs[bus.O_rf_waddr] <= bus.O_rf_wdata;
        end
        bus.I_rf_rdata_a <= regs[bus.O_rf_raddr_a];
        bus.I_rf_rdata_b <= regs[bus.O_rf_raddr_b];
    end

    // ALU: flags = {op1>op2, op1<op2, negative, zero, carry/borrow}
    logic [16:0] alu_w;
    always_comb begin
        alu_w = {1'b0, bus.O_alu_op1};
        case (bus.O_alu_opcode)
            4'h1: alu_w = {1'b0, bus.O_alu_op1 & bus.O_alu_op2};
            4'h2: alu_w = {1'b0, bus.O_alu_op1 | bus.O_alu_op2};
            4'h3: alu_w = {1'b0, bus.O_alu_op1 ^ bus.O_alu_op2};
            4'h5: alu_w = 17'(bus.O_alu_op1) + 17'(bus.O_alu_op2);
            4'hB: alu_w = 17'(bus.O_alu_op1) - 17'(bus.O_alu_op2);
            default: alu_w = {1'b0, bus.O_alu_op1};
        endcase
        bus.I_alu_dest  = alu_w[15:0];
        bus.I_alu_flags = {bus.O_alu_op1 > bus.O_alu_op2, bus.O_alu_op1 < bus.O_alu_op2,
                           alu_w[15], alu_w[15:0] == 16'd0, alu_w[16]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] prog [3];
    int          hs_t [3];
    int          wr_t [3];
    logic [15:0] wr_d [3];
    int          n_hs;
    int          n_wr;

    initial begin
        rst = 1'b1;
        rf_clear = 1'b1;
        bus.I_instr_valid = 1'b0;
        bus.I_instr = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rf_clear = 1'b0;
        #1;
        check("rst_ready", 32'(bus.O_instr_ready), 32'd1);
        check("rst_busy",  32'(busy),              32'd0);
        check("rst_we",    32'(bus.O_rf_we),       32'd0);
        check("rst_psr",   32'(psr),               32'd0);

        // Register-form ADD: R1 = R1 + R2 = 3 + 4
        @(negedge clk); bus.I_instr_valid = 1'b1; bus.I_instr = 16'h0152; #1;
        check("add_hs_ready", 32'(bus.O_instr_ready), 32'd1);
        @(negedge clk); bus.I_instr_valid = 1'b0; bus.I_instr = 16'hFFFF; #1;
        check("add_raddr_a", 32'(bus.O_rf_raddr_a), 32'd1);
        check("add_raddr_b", 32'(bus.O_rf_raddr_b), 32'd2);
        check("add_busy",    32'(busy),             32'd1);
        check("add_ready_lo", 32'(bus.O_instr_ready), 32'd0);
        @(negedge clk); #1;
        check("add_opcode", 32'(bus.O_alu_opcode), 32'h5);
        check("add_op1",    32'(bus.O_alu_op1),    32'd3);
        check("add_op2",    32'(bus.O_alu_op2),    32'd4);
        check("add_we_exec", 32'(bus.O_rf_we),     32'd0);
        @(negedge clk); #1;
        check("add_we",    32'(bus.O_rf_we),    32'd1);
        check("add_waddr", 32'(bus.O_rf_waddr), 32'd1);
        check("add_wdata", 32'(bus.O_rf_wdata), 32'd7);
        @(negedge clk); #1;
        check("add_ready", 32'(bus.O_instr_ready), 32'd1);
        check("add_psr",   32'(psr),               32'b01000);
        check("add_r1",    32'(regs[1]),           32'd7);

        // Immediate ADD with sign-extended 0xFF: R3 = 0x10 + 0xFFFF
        @(negedge clk); bus.I_instr_valid = 1'b1; bus.I_instr = 16'h53FF; #1;
        check("imm_hs_ready", 32'(bus.O_instr_ready), 32'd1);
        @(negedge clk); bus.I_instr_valid = 1'b0; bus.I_instr = 16'h0000; #1;
        check("imm_raddr_a", 32'(bus.O_rf_raddr_a), 32'd3);
        @(negedge clk); #1;
        check("imm_opcode", 32'(bus.O_alu_opcode), 32'h5);
        check("imm_op1",    32'(bus.O_alu_op1),    32'h0010);
        check("imm_op2",    32'(bus.O_alu_op2),    32'hFFFF);
        @(negedge clk); #1;
        check("imm_we",      32'(bus.O_rf_we),    32'd1);
        check("imm_waddr",   32'(bus.O_rf_waddr), 32'd3);
        check("imm_wdata",   32'(bus.O_rf_wdata), 32'h000F);
        check("imm_psr_old", 32'(psr),            32'b01000);
        @(negedge clk); #1;
        check("imm_psr", 32'(psr),     32'b01001);
        check("imm_r3",  32'(regs[3]), 32'h000F);

        // Register-form CMP R1(7) vs R2(4): flags only
        @(negedge clk); bus.I_instr_valid = 1'b1; bus.I_instr = 16'h01B2; #1;
        check("cmp_hs_ready", 32'(bus.O_instr_ready), 32'd1);
        @(negedge clk); bus.I_instr_valid = 1'b0; #1;
        check("cmp_we_read", 32'(bus.O_rf_we), 32'd0);
        @(negedge clk); #1;
        check("cmp_opcode", 32'(bus.O_alu_opcode), 32'hB);
        check("cmp_op1",    32'(bus.O_alu_op1),    32'd7);
        check("cmp_op2",    32'(bus.O_alu_op2),    32'd4);
        @(negedge clk); #1;
        check("cmp_we_wb", 32'(bus.O_rf_we), 32'd0);
        check("cmp_busy",  32'(busy),        32'd1);
        @(negedge clk); #1;
        check("cmp_psr", 32'(psr),     32'b10000);
        check("cmp_r1",  32'(regs[1]), 32'd7);

        // Back-to-back with valid held: R4 += 1, += 2, += -1
        prog[0] = 16'h5401; prog[1] = 16'h5402; prog[2] = 16'h54FF;
        n_hs = 0; n_wr = 0;
        for (int i = 0; i < 3; i++) begin hs_t[i] = -1; wr_t[i] = -1; wr_d[i] = '0; end
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            bus.I_instr_valid = (n_hs < 3);
            bus.I_instr = (n_hs < 3) ? prog[n_hs] : 16'h0000;
            #1;
            if (bus.O_rf_we) begin
                if (n_wr < 3) begin wr_t[n_wr] = t; wr_d[n_wr] = bus.O_rf_wdata; end
                n_wr++;
            end
            if (bus.I_instr_valid && bus.O_instr_ready) begin
                if (n_hs < 3) hs_t[n_hs] = t;
                n_hs++;
            end
        end
        bus.I_instr_valid = 1'b0;
        check("b2b_n_hs", 32'(n_hs), 32'd3);
        check("b2b_n_wr", 32'(n_wr), 32'd3);
        check("b2b_hs0", 32'(hs_t[0]), 32'd0);
        check("b2b_hs1", 32'(hs_t[1]), 32'd4);
        check("b2b_hs2", 32'(hs_t[2]), 32'd8);
        check("b2b_wr0", 32'(wr_t[0]), 32'd3);
        check("b2b_wr1", 32'(wr_t[1]), 32'd7);
        check("b2b_wr2", 32'(wr_t[2]), 32'd11);
        check("b2b_wd0", 32'(wr_d[0]), 32'd1);
        check("b2b_wd1", 32'(wr_d[1]), 32'd3);
        check("b2b_wd2", 32'(wr_d[2]), 32'd2);
        check("b2b_psr", 32'(psr),     32'b01001);
`ifdef CR16_ALU_CTRL_STATS_EN
        check("b2b_retired", 32'(retired), 32'd6);
`endif

        // Reset asserted during WB: write suppressed, flags cleared
        @(negedge clk); bus.I_instr_valid = 1'b1; bus.I_instr = 16'h5405; #1;
        check("rwb_hs_ready", 32'(bus.O_instr_ready), 32'd1);
        @(negedge clk); bus.I_instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rwb_we_pre",  32'(bus.O_rf_we), 32'd1);
        check("rwb_psr_pre", 32'(psr),         32'b01001);
        rst = 1'b1; #1;
        check("rwb_we_gated", 32'(bus.O_rf_we), 32'd0);
        @(negedge clk); rst = 1'b0; bus.I_instr_valid = 1'b1; bus.I_instr = 16'h5501; #1;
        check("rwb_busy",  32'(busy),              32'd0);
        check("rwb_ready", 32'(bus.O_instr_ready), 32'd1);
        check("rwb_psr",   32'(psr),               32'd0);
        check("rwb_r4",    32'(regs[4]),           32'd2);
`ifdef CR16_ALU_CTRL_STATS_EN
        check("rwb_retired", 32'(retired), 32'd0);
`endif
        @(negedge clk); bus.I_instr_valid = 1'b0; #1;
        check("new_busy",    32'(busy),             32'd1);
        check("new_raddr_a", 32'(bus.O_rf_raddr_a), 32'd5);
        @(negedge clk);
        @(negedge clk); #1;
        check("new_we",    32'(bus.O_rf_we),    32'd1);
        check("new_waddr", 32'(bus.O_rf_waddr), 32'd5);
        check("new_wdata", 32'(bus.O_rf_wdata), 32'd1);
        @(negedge clk); #1;
        check("new_psr",   32'(psr),               32'b01000);
        check("new_r5",    32'(regs[5]),           32'd1);
        check("new_ready", 32'(bus.O_instr_ready), 32'd1);
`ifdef CR16_ALU_CTRL_STATS_EN
        check("new_retired", 32'(retired), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
